// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types: shared types for the RV32I writeback stage.
//   regfilemux_sel_t : source select for the register-file write value
//   load_funct3_t    : funct3 encodings of the RV32I load instructions
//   memwb_t          : MEM/WB pipeline register contents
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [2:0] {
    alu_out  = 3'd0,
    br_en    = 3'd1,
    u_imm    = 3'd2,
    pc_plus4 = 3'd3,
    load     = 3'd4
  } regfilemux_sel_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  // Select and funct3 are kept as raw bits so that out-of-range encodings
  // arriving from upstream are carried through without an enum cast.
  typedef struct packed {
    logic        valid;
    logic        load_regfile;
    logic [2:0]  regfilemux_sel;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] u_imm;
    logic [31:0] pc;
    logic [31:0] data;
  } memwb_t;

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align: extracts the addressed byte/halfword of a memory word and
// sign- or zero-extends it according to the load funct3.
// Ports:
//   funct3_i [2:0]  load width/sign
//   offset_i [1:0]  byte offset within the word (address bits [1:0])
//   data_i   [31:0] aligned memory word
//   value_o  [31:0] extended load result (data_i unchanged for lw/unknown)
// ---------------------------------------------------------------------------
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (offset_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
  end

  // Halfword select uses only offset bit 1; a misaligned bit 0 is ignored.
  assign half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    value_o = data_i;
    case (funct3_i)
      lb:      value_o = {{24{byte_sel[7]}}, byte_sel};
      lbu:     value_o = {24'b0, byte_sel};
      lh:      value_o = {{16{half_sel[15]}}, half_sel};
      lhu:     value_o = {16'b0, half_sel};
      default: value_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage: RV32I writeback stage. Holds the MEM/WB pipeline register,
// selects the register-file write value, drives the register-file write
// port and the execute-stage bypass.
// Optional feature: define WB_INSTRET_EN to add the 64-bit instret counter.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              hold / invalidate the MEM/WB register
//   in_*                      MEM-stage instruction fields
//   data_value                aligned memory word for loads
//   rf_load, rf_rd, rf_wdata  register-file write port
//   fwd_valid, fwd_rd, fwd_data  bypass (mirrors the write port)
//   instret                   retired count (WB_INSTRET_EN only)
// ---------------------------------------------------------------------------
module wb_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_load_regfile,
  input  logic [2:0]  in_regfilemux_sel,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_out,
  input  logic        in_br_en,
  input  logic [31:0] in_u_imm,
  input  logic [31:0] in_pc,
  input  logic [31:0] data_value,
  output logic        rf_load,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  memwb_t      memwb_q, memwb_d;
  logic [31:0] load_value;
  logic [31:0] wdata;
  logic        wr_en;

  // Flush takes priority over stall; other fields simply hold on flush.
  always_comb begin
    memwb_d = memwb_q;
    if (flush) begin
      memwb_d.valid = 1'b0;
    end else if (!stall) begin
      memwb_d.valid          = in_valid;
      memwb_d.load_regfile   = in_load_regfile;
      memwb_d.regfilemux_sel = in_regfilemux_sel;
      memwb_d.rd             = in_rd;
      memwb_d.funct3         = in_funct3;
      memwb_d.alu_out        = in_alu_out;
      memwb_d.br_en          = in_br_en;
      memwb_d.u_imm          = in_u_imm;
      memwb_d.pc             = in_pc;
      memwb_d.data           = data_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  load_align u_load_align (
    .funct3_i (memwb_q.funct3),
    .offset_i (memwb_q.alu_out[1:0]),
    .data_i   (memwb_q.data),
    .value_o  (load_value)
  );

  always_comb begin
    wdata = memwb_q.alu_out;
    case (memwb_q.regfilemux_sel)
      alu_out:  wdata = memwb_q.alu_out;
      br_en:    wdata = {31'b0, memwb_q.br_en};
      u_imm:    wdata = memwb_q.u_imm;
      pc_plus4: wdata = memwb_q.pc + 32'd4;
      load:     wdata = load_value;
      default:  wdata = memwb_q.alu_out;
    endcase
  end

  // x0 is hard-wired zero: never written, never forwarded.
  assign wr_en     = memwb_q.valid & memwb_q.load_regfile & (memwb_q.rd != '0);

  assign rf_load   = wr_en;
  assign rf_rd     = memwb_q.rd;
  assign rf_wdata  = wdata;
  assign fwd_valid = wr_en;
  assign fwd_rd    = memwb_q.rd;
  assign fwd_data  = wdata;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // An instruction retires on the edge where it leaves the stage.
  always_comb begin
    instret_d = instret_q;
    if (memwb_q.valid && !stall) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule
